uart_frame_rx: RTL and testbench
================================

// Module: uart_frame_rx
// PURPOSE
//  FPGA-side receiver for the Nano->FPGA UART link; the return path of the FPGA->Nano transmitter.
//  Oversamples the serial line, deserialises bytes and parses command frames [SYNC][LEN][PAYLOAD x LEN][CHK].
//  Buffers each payload and releases it on a valid/ready byte stream only after the checksum passes.
// PARAMETERS
//  CLKS_PER_BIT  434 (50e6/115200)  clk cycles per UART bit
//  BITS_N        8                   data bits per UART frame
//  PARITY_TYPE   0                   0 none, 1 odd, 2 even
//  SYNC_BYTE     8'hA5               frame start marker
//  MAX_LEN       16                  max payload bytes; buffer depth
// PORTS
//  clk           in   1                    system clock
//  rst           in   1                    asynchronous reset, active-high
//  uart_in       in   1                    serial line from Nano, idles high
//  data_out      out  BITS_N               payload byte
//  valid_out     out  1                    data_out valid
//  ready_in      in   1                    consumer accepts byte when valid_out&ready_in
//  last_out      out  1                    marks final payload byte of frame
//  frame_len     out  $clog2(MAX_LEN+1)    LEN of frame being drained
//  busy          out  1                    buffer holds an undrained frame
//  baud_trigger  out  1                    1-cycle pulse at every bit sample point
//  err_framing   out  1                    1-cycle pulse: stop bit sampled 0
//  err_parity    out  1                    1-cycle pulse: parity mismatch
//  err_checksum  out  1                    1-cycle pulse: CHK mismatch
//  err_length    out  1                    1-cycle pulse: LEN==0 or LEN>MAX_LEN
//  err_overrun   out  1                    1-cycle pulse: SYNC received while busy
// BEHAVIOUR
//  Reset: all outputs 0, data_out 0, both FSMs to idle states, buffer pointers 0.
//  Reset mid-frame: partial frame and undrained buffer discarded.
//  uart_in passes a 2-flop synchroniser (reset to 1) before any use.
//  Bit FSM (IDLE,START,DATA,PARITY,STOP):
//   - IDLE: wait for 1->0 on synced line.
//   - START: wait CLKS_PER_BIT/2; line high -> IDLE (glitch, no error); else DATA.
//   - DATA: sample every CLKS_PER_BIT, LSB first, BITS_N bits.
//   - PARITY: present only if PARITY_TYPE!=0.
//   - STOP: sample 1 full bit later; 0 -> err_framing, byte dropped.
//   - baud_trigger pulses at each START/DATA/PARITY/STOP sample.
//   - Byte strobe issued on good STOP sample; FSM returns to IDLE same cycle.
//  Parse FSM (WAIT_SYNC,LEN,PAYLOAD,CHK), advances one step per byte strobe:
//   - WAIT_SYNC: non-SYNC bytes ignored. SYNC while busy -> err_overrun, stay.
//   - LEN: 0 or >MAX_LEN -> err_length, WAIT_SYNC.
//   - PAYLOAD: bytes written to buffer addr 0..LEN-1.
//   - CHK: sum = (LEN + all payload bytes) mod 256.
//     Match -> busy=1, frame_len=LEN. Mismatch -> err_checksum, buffer discarded. Either case -> WAIT_SYNC.
//   - Any parity/framing error inside a frame aborts to WAIT_SYNC; partial frame discarded.
//  Output stream:
//   - valid_out rises the cycle after busy rises (1 clk after CHK stop sample).
//   - Bytes appear in arrival order. data_out/last_out held stable while valid_out&!ready_in.
//   - last_out=1 only with byte LEN-1.
//   - Accepting the last byte clears valid_out and busy next cycle.
//   - A SYNC arriving on the cycle busy clears is accepted as a new frame.
//  Error pulses may coincide; each fires exactly one cycle per event.
// TESTING
//  1. Send A5 03 10 20 30 63, ready_in=1 -> out 10,20,30; last_out on 30; frame_len=3; no errors.
//  2. Send A5 02 AA BB 00 -> err_checksum pulse once; valid_out never asserts.
//  3. 100-clk low glitch on idle line, then frame 1 -> no error; frame 1 delivered intact.
//  4. Frame 1 with ready_in toggled 1-in-3 -> same 3 bytes, data_out stable while stalled.
//  5. Frame 1, ready_in=0, then send A5 01 55 56 -> err_overrun; first frame drains unchanged.
//  6. Assert rst mid-PAYLOAD, release, send frame 1 -> only frame 1 out; LEN=17 -> err_length.

Source files
------------

// File: rtl/uart_frame_rx.sv
// UART receiver for the Nano->FPGA link: oversampled bit FSM, frame parser
// [SYNC][LEN][PAYLOAD][CHK], and a payload buffer released as a valid/ready stream.
module uart_frame_rx #(
    parameter int                 CLKS_PER_BIT = 434,
    parameter int                 BITS_N       = 8,
    parameter int                 PARITY_TYPE  = 0,
    parameter logic [BITS_N-1:0]  SYNC_BYTE    = 'hA5,
    parameter int                 MAX_LEN      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           uart_in,
    output logic [BITS_N-1:0]              data_out,
    output logic                           valid_out,
    input  logic                           ready_in,
    output logic                           last_out,
    output logic [$clog2(MAX_LEN+1)-1:0]   frame_len,
    output logic                           busy,
    output logic                           baud_trigger,
    output logic                           err_framing,
    output logic                           err_parity,
    output logic                           err_checksum,
    output logic                           err_length,
    output logic                           err_overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (BITS_N > 1) ? $clog2(BITS_N) : 1;
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0]     FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]     HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0]     LAST_BIT  = BW'(BITS_N - 1);
    localparam logic [BITS_N-1:0] MAX_LEN_B = BITS_N'(MAX_LEN);

    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PARITY, B_STOP} bit_st_t;
    typedef enum logic [1:0] {P_WAIT_SYNC, P_LEN, P_PAYLOAD, P_CHK} prs_st_t;

    // ---------------- input synchroniser ----------------
    logic [1:0] r_sync;
    logic       r_rx_prev;
    logic       w_rx;

    assign w_rx = r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], uart_in};
            r_rx_prev <= w_rx;
        end
    end

    // ---------------- bit FSM ----------------
    bit_st_t           r_bst, w_bst_nxt;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     r_bit_idx;
    logic [BITS_N-1:0] r_shift;
    logic              r_par_bad;
    logic              w_tick_half, w_tick_full, w_par_exp;
    logic              w_sample, w_byte_stb, w_frame_err, w_par_err;

    assign w_tick_half = (r_cnt == HALF_M1);
    assign w_tick_full = (r_cnt == FULL_M1);
    assign w_par_exp   = (PARITY_TYPE == 1) ? ~^r_shift : ^r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_bst <= B_IDLE;
        else     r_bst <= w_bst_nxt;
    end

    always_comb begin
        w_bst_nxt = r_bst;
        case (r_bst)
            B_IDLE:   if (r_rx_prev && !w_rx) w_bst_nxt = B_START;
            B_START:  if (w_tick_half) w_bst_nxt = w_rx ? B_IDLE : B_DATA;
            B_DATA:   if (w_tick_full && r_bit_idx == LAST_BIT)
                          w_bst_nxt = (PARITY_TYPE != 0) ? B_PARITY : B_STOP;
            B_PARITY: if (w_tick_full) w_bst_nxt = B_STOP;
            B_STOP:   if (w_tick_full) w_bst_nxt = B_IDLE;
            default:  w_bst_nxt = B_IDLE;
        endcase
    end

    always_comb begin
        w_sample    = 1'b0;
        w_byte_stb  = 1'b0;
        w_frame_err = 1'b0;
        w_par_err   = 1'b0;
        case (r_bst)
            B_START:  w_sample = w_tick_half;
            B_DATA:   w_sample = w_tick_full;
            B_PARITY: begin
                w_sample  = w_tick_full;
                w_par_err = w_tick_full && (w_rx != w_par_exp);
            end
            B_STOP: begin
                w_sample    = w_tick_full;
                w_byte_stb  = w_tick_full && w_rx && !r_par_bad;
                w_frame_err = w_tick_full && !w_rx;
            end
            default: ;
        endcase
    end

    // Counter restarts at every sample so each bit period is measured from the last sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            r_cnt <= (r_bst == B_IDLE || w_sample) ? '0 : r_cnt + 1'b1;
            if (r_bst == B_START) begin
                r_bit_idx <= '0;
                r_par_bad <= 1'b0;
            end
            if (r_bst == B_DATA && w_tick_full) begin
                r_shift   <= {w_rx, r_shift[BITS_N-1:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (r_bst == B_PARITY && w_tick_full)
                r_par_bad <= (w_rx != w_par_exp);
        end
    end

    // ---------------- parse FSM ----------------
    prs_st_t           r_pst, w_pst_nxt;
    logic [LW-1:0]     r_len, r_wr_ptr;
    logic [BITS_N-1:0] r_sum;
    logic [BITS_N-1:0] w_byte;
    logic              w_abort, w_len_bad, w_drain_done, w_busy_eff;
    logic              w_buf_we, w_commit, w_chk_err, w_len_err, w_ovr_err;
    logic              r_busy, r_valid, r_last;

    assign w_byte       = r_shift;
    assign w_abort      = w_par_err | w_frame_err;
    assign w_len_bad    = (w_byte == '0) || (w_byte > MAX_LEN_B);
    assign w_drain_done = r_valid && ready_in && r_last;
    // Buffer counts as free on the cycle its last byte is taken
    assign w_busy_eff   = r_busy && !w_drain_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pst <= P_WAIT_SYNC;
        else     r_pst <= w_pst_nxt;
    end

    always_comb begin
        w_pst_nxt = r_pst;
        if (w_abort) begin
            w_pst_nxt = P_WAIT_SYNC;
        end else if (w_byte_stb) begin
            case (r_pst)
                P_WAIT_SYNC: if (w_byte == SYNC_BYTE && !w_busy_eff) w_pst_nxt = P_LEN;
                P_LEN:       w_pst_nxt = w_len_bad ? P_WAIT_SYNC : P_PAYLOAD;
                P_PAYLOAD:   if (r_wr_ptr == r_len - 1'b1) w_pst_nxt = P_CHK;
                P_CHK:       w_pst_nxt = P_WAIT_SYNC;
                default:     w_pst_nxt = P_WAIT_SYNC;
            endcase
        end
    end

    always_comb begin
        w_buf_we  = w_byte_stb && (r_pst == P_PAYLOAD);
        w_commit  = w_byte_stb && (r_pst == P_CHK) && (w_byte == r_sum);
        w_chk_err = w_byte_stb && (r_pst == P_CHK) && (w_byte != r_sum);
        w_len_err = w_byte_stb && (r_pst == P_LEN) && w_len_bad;
        w_ovr_err = w_byte_stb && (r_pst == P_WAIT_SYNC) && (w_byte == SYNC_BYTE) && w_busy_eff;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len    <= '0;
            r_wr_ptr <= '0;
            r_sum    <= '0;
        end else if (w_byte_stb && r_pst == P_LEN) begin
            r_len    <= w_byte[LW-1:0];
            r_sum    <= w_byte;
            r_wr_ptr <= '0;
        end else if (w_buf_we) begin
            r_sum    <= r_sum + w_byte;
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    logic [BITS_N-1:0] r_buf [MAX_LEN];

    always_ff @(posedge clk) begin
        if (w_buf_we) r_buf[r_wr_ptr[AW-1:0]] <= w_byte;
    end

    // ---------------- error pulses ----------------
    logic r_err_frm, r_err_par, r_err_chk, r_err_len, r_err_ovr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_frm <= 1'b0;
            r_err_par <= 1'b0;
            r_err_chk <= 1'b0;
            r_err_len <= 1'b0;
            r_err_ovr <= 1'b0;
        end else begin
            r_err_frm <= w_frame_err;
            r_err_par <= w_par_err;
            r_err_chk <= w_chk_err;
            r_err_len <= w_len_err;
            r_err_ovr <= w_ovr_err;
        end
    end

    // ---------------- output stream ----------------
    logic [LW-1:0]     r_rd_ptr, r_frame_len;
    logic [BITS_N-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= '0;
            r_rd_ptr    <= '0;
            r_frame_len <= '0;
        end else if (w_commit) begin
            r_busy      <= 1'b1;
            r_frame_len <= r_len;
            r_rd_ptr    <= '0;
        end else if (r_busy && (!r_valid || ready_in)) begin
            if (r_valid && r_last) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_valid  <= 1'b1;
                r_data   <= r_buf[r_rd_ptr[AW-1:0]];
                r_last   <= (r_rd_ptr == r_frame_len - 1'b1);
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign data_out     = r_data;
    assign valid_out    = r_valid;
    assign last_out     = r_last;
    assign frame_len    = r_frame_len;
    assign busy         = r_busy;
    assign baud_trigger = w_sample;
    assign err_framing  = r_err_frm;
    assign err_parity   = r_err_par;
    assign err_checksum = r_err_chk;
    assign err_length   = r_err_len;
    assign err_overrun  = r_err_ovr;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: serial frames driven bit by bit, outputs
// captured on the falling clock edge and compared with hand-computed values.
module tb_uart_frame_rx;

    localparam int CPB = 32;
    localparam int E_FRM = 0, E_PAR = 1, E_CHK = 2, E_LEN = 3, E_OVR = 4, E_BAUD = 5, E_VLD = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_in = 1'b1;
    logic       ready_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, last_out, busy, baud_trigger;
    logic       err_framing, err_parity, err_checksum, err_length, err_overrun;
    logic [4:0] frame_len;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] q_data[$];
    logic       q_last[$];
    logic [4:0] q_len[$];
    int         qb;
    int         cnt[7];
    int         snap[7];
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    uart_frame_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(0),
                    .SYNC_BYTE(8'hA5), .MAX_LEN(16)) dut (
        .clk(clk), .rst(rst), .uart_in(uart_in),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
        .last_out(last_out), .frame_len(frame_len), .busy(busy),
        .baud_trigger(baud_trigger), .err_framing(err_framing),
        .err_parity(err_parity), .err_checksum(err_checksum),
        .err_length(err_length), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 7; k++) cnt[k] = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
    end

    // Capture accepted bytes, count pulses, and watch stalled outputs stay put
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", valid_out, 1);
                check("stall_data", data_out, prev_data);
                check("stall_last", last_out, prev_last);
            end
            if (valid_out && ready_in) begin
                q_data.push_back(data_out);
                q_last.push_back(last_out);
                q_len.push_back(frame_len);
            end
            cnt[E_FRM]  += int'(err_framing);
            cnt[E_PAR]  += int'(err_parity);
            cnt[E_CHK]  += int'(err_checksum);
            cnt[E_LEN]  += int'(err_length);
            cnt[E_OVR]  += int'(err_overrun);
            cnt[E_BAUD] += int'(baud_trigger);
            cnt[E_VLD]  += int'(valid_out);
            prev_stall = valid_out && !ready_in;
            prev_data  = data_out;
            prev_last  = last_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stp);
        uart_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            tick(CPB);
        end
        uart_in = stp;
        tick(CPB);
        uart_in = 1'b1;
        tick(4);
    endtask

    task automatic send_frame1();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'h63, 1'b1);
    endtask

    task automatic mark();
        for (int k = 0; k < 7; k++) snap[k] = cnt[k];
        qb = q_data.size();
    endtask

    function automatic int d(input int k);
        return cnt[k] - snap[k];
    endfunction

    task automatic wait_out(input string tag, input int n);
        int k;
        k = 0;
        while ((q_data.size() - qb) < n && k < 3000) begin
            tick(1);
            k++;
        end
        check(tag, q_data.size() - qb, n);
    endtask

    task automatic check_frame1(input string tag);
        check({tag, "_n"}, q_data.size() - qb, 3);
        if (q_data.size() >= qb + 3) begin
            check({tag, "_b0"}, q_data[qb],     8'h10);
            check({tag, "_b1"}, q_data[qb + 1], 8'h20);
            check({tag, "_b2"}, q_data[qb + 2], 8'h30);
            check({tag, "_last"}, {q_last[qb], q_last[qb + 1], q_last[qb + 2]}, 3'b001);
            check({tag, "_len"}, q_len[qb], 3);
        end
    endtask

    task automatic check_no_err(input string tag);
        check(tag, d(E_FRM) + d(E_PAR) + d(E_CHK) + d(E_LEN) + d(E_OVR), 0);
    endtask

    initial begin
        // reset state
        tick(3);
        @(negedge clk);
        check("reset_outs", {data_out, valid_out, last_out, frame_len, busy, baud_trigger,
                             err_framing, err_parity, err_checksum, err_length, err_overrun}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(10);

        // good frame, consumer always ready
        mark();
        ready_in = 1'b1;
        send_frame1();
        wait_out("t1_wait", 3);
        tick(5);
        check_frame1("t1");
        check_no_err("t1_err");
        check("t1_baud", d(E_BAUD), 60);
        check("t1_idle", {busy, valid_out}, 2'b00);

        // checksum mismatch: 02+AA+BB = 0x67, not 0x00
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'h00, 1'b1);
        tick(20);
        check("t2_chk", d(E_CHK), 1);
        check("t2_valid", d(E_VLD), 0);
        check("t2_other", d(E_FRM) + d(E_LEN) + d(E_OVR), 0);
        check("t2_busy", busy, 0);

        // short low glitch is rejected at the start-bit check
        mark();
        uart_in = 1'b0;
        tick(10);
        uart_in = 1'b1;
        tick(100);
        check("t3_baud", d(E_BAUD), 1);
        send_frame1();
        wait_out("t3_wait", 3);
        tick(5);
        check_frame1("t3");
        check_no_err("t3_err");

        // stalled consumer, then ready 1-in-3
        mark();
        ready_in = 1'b0;
        send_frame1();
        tick(5);
        check("t4_hold", {valid_out, busy, last_out, data_out, frame_len}, {1'b1, 1'b1, 1'b0, 8'h10, 5'd3});
        for (int k = 0; k < 60 && (q_data.size() - qb) < 3; k++) begin
            ready_in = (k % 3 == 0);
            tick(1);
        end
        ready_in = 1'b1;
        tick(3);
        check_frame1("t4");
        check("t4_busy", busy, 0);

        // overrun while the buffer is still full
        mark();
        ready_in = 1'b0;
        send_frame1();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h56, 1'b1);
        tick(10);
        check("t5_ovr", d(E_OVR), 1);
        check("t5_none", q_data.size() - qb, 0);
        check("t5_busy", busy, 1);
        ready_in = 1'b1;
        wait_out("t5_wait", 3);
        tick(20);
        check_frame1("t5");
        check("t5_chk", d(E_CHK) + d(E_LEN) + d(E_FRM), 0);
        check("t5_busy_end", busy, 0);

        // reset in the middle of the payload
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h10, 1'b1);
        uart_in = 1'b0;
        tick(CPB * 3);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        uart_in = 1'b1;
        tick(20);
        check("t6_rst", {busy, valid_out, frame_len}, 0);
        send_frame1();
        wait_out("t6_wait", 3);
        tick(20);
        check_frame1("t6");
        check_no_err("t6_err");

        // length bounds
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        tick(10);
        check("t7_len17", d(E_LEN), 1);
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        tick(10);
        check("t7_len0", d(E_LEN), 1);

        // full 16-byte payload 1..16: chk = 0x10 + 136 = 0x98
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b1);
        send_byte(8'h98, 1'b1);
        wait_out("t8_wait", 16);
        tick(5);
        if (q_data.size() >= qb + 16) begin
            check("t8_b0", q_data[qb], 8'h01);
            check("t8_b15", q_data[qb + 15], 8'h10);
            check("t8_last14", q_last[qb + 14], 0);
            check("t8_last15", q_last[qb + 15], 1);
            check("t8_len", q_len[qb], 16);
        end
        check_no_err("t8_err");

        // framing error inside a frame aborts it
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        tick(10);
        check("t9_frm", d(E_FRM), 1);
        check("t9_len", d(E_LEN), 0);
        check("t9_none", q_data.size() - qb, 0);
        mark();
        send_frame1();
        wait_out("t9_wait", 3);
        tick(5);
        check_frame1("t9");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
